// File: rtl/sub_bytes_engine.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_engine
// Purpose  : Forward AES SubBytes engine. Accepts a 128-bit state over a
//            valid/ready handshake, substitutes BPC bytes per cycle through
//            forward S-box lookups and returns the substituted state over a
//            valid/ready handshake. One state in flight at a time.
// Revision : 1.0  initial release
// ============================================================================
module sub_bytes_engine #(
   parameter int BPC = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int            NGRP     = 16 / BPC;
   localparam int            CW       = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam logic [CW-1:0] LAST_GRP = CW'(NGRP - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [CW-1:0] r_cnt;
   logic [127:0]  r_work;
   logic [127:0]  r_out;
   logic [127:0]  w_work_sub;
   logic          w_accept;
   logic          w_last;

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1, shift-and-add form.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Forward S-box: multiplicative inverse as x^254 (maps 0 to 0), then affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      inv  = gf_mul(gf_mul(x240, x12), x2);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Per-byte substitution: only the bytes of the group selected by the counter change.
   for (genvar j = 0; j < 16; j++) begin : g_byte
      localparam int GRP = j / BPC;
      logic [7:0] w_byte;
      assign w_byte = r_work[127-8*j -: 8];
      assign w_work_sub[127-8*j -: 8] = (r_cnt == GRP[CW-1:0]) ? sbox(w_byte) : w_byte;
   end

   assign w_accept = in_valid & in_ready;
   assign w_last   = (r_cnt == LAST_GRP);
   assign out_data = r_out;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state and handshake outputs; in_ready is held low while reset is asserted.
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = rst_n;
            if (in_valid && rst_n) w_state_next = SUB;
         end
         SUB: begin
            busy = 1'b1;
            if (w_last) w_state_next = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Datapath: capture on accept, substitute one group per SUB cycle, latch the result on the last group.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_work <= '0;
         r_out  <= '0;
         r_cnt  <= '0;
      end else if (w_accept) begin
         r_work <= in_data;
         r_cnt  <= '0;
      end else if (r_state == SUB) begin
         r_work <= w_work_sub;
         if (w_last) begin
            r_out <= w_work_sub;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_bytes_engine
// Purpose  : Self-checking bench for sub_bytes_engine; instance 0 uses BPC=4,
//            instances 1..4 use BPC=1,2,8,16.
// Revision : 1.0  initial release
// ============================================================================
module tb_sub_bytes_engine;

   logic          clk;
   logic          rst_n;
   logic [4:0]    in_valid_v;
   logic [4:0]    in_ready_v;
   logic [4:0]    out_valid_v;
   logic [4:0]    out_ready_v;
   logic [4:0]    busy_v;
   logic [127:0]  in_data_v  [5];
   logic [127:0]  out_data_v [5];

   int total;
   int bad;

   logic [7:0] fwd_tab [256];
   logic [7:0] inv_tab [256];

   localparam logic [127:0] V1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] V1_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

   for (genvar k = 0; k < 5; k++) begin : g_dut
      localparam int B = (k == 0) ? 4 : (k == 1) ? 1 : (k == 2) ? 2 : (k == 3) ? 8 : 16;
      sub_bytes_engine #(.BPC(B)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid_v[k]),
         .in_ready  (in_ready_v[k]),
         .in_data   (in_data_v[k]),
         .out_valid (out_valid_v[k]),
         .out_ready (out_ready_v[k]),
         .out_data  (out_data_v[k]),
         .busy      (busy_v[k])
      );
   end

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Absolute time limit.
   initial begin
      #5000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", nm, got, exp);
      end
   endtask

   // Carry-less product then reduction by 0x11b.
   function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (15'({7'b0, a}) << i);
      for (int i = 14; i >= 8; i--)
         if (p[i]) p = p ^ (15'h11b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [127:0] apply_tab(input logic [127:0] d, input bit use_inv);
      logic [127:0] r;
      r = d;
      for (int j = 0; j < 16; j++)
         r[127-8*j -: 8] = use_inv ? inv_tab[d[127-8*j -: 8]] : fwd_tab[d[127-8*j -: 8]];
      return r;
   endfunction

   // Drive one state into instance k with out_ready high, check latency, result and return to IDLE.
   task automatic run_vec(input int k, input logic [127:0] din, input logic [127:0] exp,
                          input int exp_lat, input string nm);
      int n;
      int lat;
      @(negedge clk);
      in_valid_v[k]  = 1'b1;
      in_data_v[k]   = din;
      out_ready_v[k] = 1'b1;
      n = 0;
      while (!in_ready_v[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         chk({nm, " accept_timeout"}, 128'(in_ready_v[k]), 128'd1);
         in_valid_v[k] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid_v[k] = 1'b0;
      lat = 1;
      while (!out_valid_v[k] && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({nm, " latency"}, 128'(lat), 128'(exp_lat));
      chk({nm, " data"}, out_data_v[k], exp);
      @(posedge clk);
      #1;
      chk({nm, " valid_drop"}, 128'(out_valid_v[k]), 128'd0);
      chk({nm, " ready_back"}, 128'(in_ready_v[k]), 128'd1);
      out_ready_v[k] = 1'b0;
   endtask

   typedef struct {
      logic [127:0] din;
      logic [127:0] exp;
   } vec_t;

   initial begin
      vec_t         vt [4];
      logic [7:0]   c;
      logic [7:0]   iv;
      logic [7:0]   b;
      logic [127:0] rnd;
      logic [127:0] held;
      int           n;
      int           lats [5];

      total = 0;
      bad   = 0;

      vt[0] = '{V1_IN, V1_OUT};
      vt[1] = '{128'h0, {16{8'h63}}};
      vt[2] = '{{16{8'hff}}, {16{8'h16}}};
      vt[3] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76};
      lats  = '{5, 17, 9, 3, 2};

      // Reference S-box from brute-force inverse and per-bit affine transform.
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         iv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (tb_gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
         for (int i = 0; i < 8; i++)
            b[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ c[i];
         fwd_tab[x] = b;
         inv_tab[b] = 8'(x);
      end

      rst_n       = 1'b0;
      in_valid_v  = '0;
      out_ready_v = '0;
      for (int k = 0; k < 5; k++) in_data_v[k] = '0;

      // Reset values while rst_n is held low.
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("rst in_ready[%0d]", k), 128'(in_ready_v[k]), 128'd0);
         chk($sformatf("rst out_valid[%0d]", k), 128'(out_valid_v[k]), 128'd0);
         chk($sformatf("rst busy[%0d]", k), 128'(busy_v[k]), 128'd0);
         chk($sformatf("rst out_data[%0d]", k), out_data_v[k], 128'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 5; k++)
         chk($sformatf("post_rst in_ready[%0d]", k), 128'(in_ready_v[k]), 128'd1);

      // Known-answer table on the BPC=4 instance.
      for (int i = 0; i < 4; i++)
         run_vec(0, vt[i].din, vt[i].exp, 5, $sformatf("kat%0d", i));

      // Backpressure in DONE with in_valid asserted and ignored.
      @(negedge clk);
      in_valid_v[0]  = 1'b1;
      in_data_v[0]   = V1_IN;
      out_ready_v[0] = 1'b0;
      @(posedge clk);
      #1;
      in_data_v[0] = 128'hdeadbeef_00000000_12345678_9abcdef0;
      n = 0;
      while (!out_valid_v[0] && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("bp reach_done", 128'(out_valid_v[0]), 128'd1);
      held = out_data_v[0];
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("bp out_valid", 128'(out_valid_v[0]), 128'd1);
         chk("bp out_data", out_data_v[0], V1_OUT);
         chk("bp stable", out_data_v[0], held);
         chk("bp in_ready", 128'(in_ready_v[0]), 128'd0);
      end
      @(negedge clk);
      out_ready_v[0] = 1'b1;
      in_valid_v[0]  = 1'b0;
      @(posedge clk);
      #1;
      chk("bp release out_valid", 128'(out_valid_v[0]), 128'd0);
      chk("bp release in_ready", 128'(in_ready_v[0]), 128'd1);
      chk("bp release busy", 128'(busy_v[0]), 128'd0);
      out_ready_v[0] = 1'b0;

      // Async reset during the second SUB cycle, then a fresh vector.
      @(negedge clk);
      in_valid_v[0]  = 1'b1;
      in_data_v[0]   = vt[3].din;
      out_ready_v[0] = 1'b1;
      @(posedge clk);
      #1;
      in_valid_v[0] = 1'b0;
      chk("ar busy_in_sub", 128'(busy_v[0]), 128'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar out_valid", 128'(out_valid_v[0]), 128'd0);
      chk("ar busy", 128'(busy_v[0]), 128'd0);
      chk("ar in_ready", 128'(in_ready_v[0]), 128'd0);
      chk("ar out_data", out_data_v[0], 128'd0);
      @(posedge clk);
      #1;
      chk("ar held out_valid", 128'(out_valid_v[0]), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(0, V1_IN, V1_OUT, 5, "after_reset");

      // BPC sweep on the remaining instances.
      for (int k = 1; k < 5; k++)
         run_vec(k, V1_IN, V1_OUT, lats[k], $sformatf("sweep%0d", k));
      run_vec(4, {16{8'hff}}, {16{8'h16}}, 2, "bpc16_ff");

      // Random states: result matches the reference and inverts back to the input.
      for (int i = 0; i < 1000; i++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         run_vec(0, rnd, apply_tab(rnd, 1'b0), 5, "rand");
         chk("rand inverse", apply_tab(out_data_v[0], 1'b1), rnd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
